// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: start/snapshot inputs and row-stream handshake of the result drain (row_parity present under DRAIN_PARITY_EN)
interface systolic_result_drain_if #(
  parameter int N     = 3,
  parameter int ACC_W = 17
);
  localparam int IW = $clog2(N);
  logic                 start;
  logic [N*N*ACC_W-1:0] c_flat;
  logic                 out_ready;
  logic                 row_valid;
  logic [N*ACC_W-1:0]   row_data;
  logic [IW-1:0]        row_idx;
  logic                 clear_acc;
  logic                 busy;
  logic                 overrun;
`ifdef DRAIN_PARITY_EN
  logic                 row_parity;
  modport master (output start, c_flat, out_ready,
                  input  row_valid, row_data, row_idx, clear_acc, busy, overrun, row_parity);
  modport slave  (input  start, c_flat, out_ready,
                  output row_valid, row_data, row_idx, clear_acc, busy, overrun, row_parity);
`else
  modport master (output start, c_flat, out_ready,
                  input  row_valid, row_data, row_idx, clear_acc, busy, overrun);
  modport slave  (input  start, c_flat, out_ready,
                  output row_valid, row_data, row_idx, clear_acc, busy, overrun);
`endif
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshot N x N accumulators after the compute window and stream them out row by row (optional DRAIN_PARITY_EN adds row_parity)
module systolic_result_drain #(
  parameter int N              = 3,
  parameter int ACC_W          = 17,
  parameter int COMPUTE_CYCLES = 7
) (
  input logic                   clk,
  input logic                   reset,
  systolic_result_drain_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  localparam int RW = N * ACC_W;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_snap [N];
  logic [RW-1:0] r_row_data;
  logic [IW-1:0] r_row_idx;
  logic          r_row_valid;
  logic          r_clear_acc;
  logic          r_busy;
  logic          r_overrun;
  logic [IW-1:0] w_next_idx;
  logic [RW-1:0] w_first_row;
`ifdef DRAIN_PARITY_EN
  logic          r_parity;
`endif
  // next row index during drain and row 0 straight from the array (it is snapshotted on the same edge)
  always_comb begin
    w_next_idx  = r_row_idx + IW'(1);
    w_first_row = bus.c_flat[RW-1:0];
  end
  // sequencing FSM: count compute window, snapshot, then hand rows out on each handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
      r_clear_acc <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < N; i++) r_snap[i] <= '0;
`ifdef DRAIN_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_clear_acc <= 1'b0;
      if (bus.start && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= WAIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        WAIT: if (r_cnt == CW'(COMPUTE_CYCLES - 1)) begin
          for (int i = 0; i < N; i++) r_snap[i] <= bus.c_flat[i*RW +: RW];
          r_row_data  <= w_first_row;
          r_row_idx   <= '0;
          r_row_valid <= 1'b1;
          r_clear_acc <= 1'b1;
          r_state     <= DRAIN;
`ifdef DRAIN_PARITY_EN
          r_parity    <= ^w_first_row;
`endif
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        DRAIN: if (r_row_valid && bus.out_ready) begin
          if (r_row_idx == IW'(N - 1)) begin
            r_state     <= IDLE;
            r_row_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_row_idx  <= w_next_idx;
            r_row_data <= r_snap[w_next_idx];
`ifdef DRAIN_PARITY_EN
            r_parity   <= ^r_snap[w_next_idx];
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.row_valid = r_row_valid;
  assign bus.row_data  = r_row_data;
  assign bus.row_idx   = r_row_idx;
  assign bus.clear_acc = r_clear_acc;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;
`ifdef DRAIN_PARITY_EN
  assign bus.row_parity = r_parity;
`endif
endmodule
